// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: program-memory port, redirect request, and the decode-side handshake.
interface instruction_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  enable;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] pc;
  logic                  valid;
  logic                  ready;
  logic                  fault;
  logic [DATA_WIDTH-1:0] fault_addr;
  logic [DATA_WIDTH-1:0] fetch_count;

  modport master (
    input  enable, redirect, target, mem_data, ready,
    output address, instruction, pc, valid, fault, fault_addr, fetch_count
  );

  modport slave (
    output enable, redirect, target, mem_data, ready,
    input  address, instruction, pc, valid, fault, fault_addr, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-entry instruction fetch stage: PC sequencing, redirect, range/alignment
// fault trapping and an accepted-entry counter.
module instruction_fetch_unit #(
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] LimitAddr = BASE_ADDR + DATA_WIDTH'(4 * MEMORY_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_out_q;
  logic                  valid_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] fault_addr_q;
  logic [DATA_WIDTH-1:0] count_q;

  logic fire;
  logic load_req;
  logic in_range;

  assign fire     = valid_q & bus.ready;
  // Redirect has priority; it is handled first in the sequential block.
  assign load_req = (state_q == StRun) & bus.enable & (~valid_q | bus.ready);
  assign in_range = (pc_q >= BASE_ADDR) && (pc_q < LimitAddr) && (pc_q[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= BASE_ADDR;
      instr_q      <= '0;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      count_q      <= '0;
    end else begin
      if (fire) count_q <= count_q + DATA_WIDTH'(1);
      case (state_q)
        StIdle, StRun: begin
          state_q <= bus.enable ? StRun : StIdle;
          if (bus.redirect) begin
            valid_q <= 1'b0;
            if (bus.target[1:0] != 2'b00) begin
              state_q      <= StFault;
              fault_q      <= 1'b1;
              fault_addr_q <= bus.target;
            end else begin
              pc_q <= bus.target;
            end
          end else if (load_req) begin
            if (in_range) begin
              instr_q  <= bus.mem_data;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_q + DATA_WIDTH'(4);
            end else begin
              state_q      <= StFault;
              fault_q      <= 1'b1;
              fault_addr_q <= pc_q;
              valid_q      <= 1'b0;
            end
          end else if (fire) begin
            valid_q <= 1'b0;
          end
        end
        StFault: valid_q <= 1'b0;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.address     = pc_q;
  assign bus.instruction = instr_q;
  assign bus.pc          = pc_out_q;
  assign bus.valid       = valid_q;
  assign bus.fault       = fault_q;
  assign bus.fault_addr  = fault_addr_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus end-of-memory,
// out-of-range redirect and reset-override sequences.
module tb_instruction_fetch_unit;

  localparam logic [31:0] Base = 32'h0040_0000;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

  instruction_fetch_unit #(
    .MEMORY_DEPTH(64),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (Base)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Program memory: word n holds n; anything outside the 64 words reads as a marker.
  assign bus.mem_data = (bus.address >= Base && bus.address < Base + 32'd256) ?
                        ((bus.address - Base) >> 2) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rd;
    logic [31:0] tgt;
    logic        rdy;
    logic        valid;
    logic [31:0] pc_o;
    logic [31:0] instr;
    logic [31:0] count;
    logic        fault;
    logic [31:0] faddr;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic valid, input logic [31:0] pc_o,
                         input logic [31:0] instr, input logic [31:0] count, input logic fault,
                         input logic [31:0] faddr, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'd0, bus.valid}, {31'd0, valid});
    chk({tag, ".pc"}, bus.pc, pc_o);
    chk({tag, ".instr"}, bus.instruction, instr);
    chk({tag, ".count"}, bus.fetch_count, count);
    chk({tag, ".fault"}, {31'd0, bus.fault}, {31'd0, fault});
    chk({tag, ".faddr"}, bus.fault_addr, faddr);
    chk({tag, ".addr"}, bus.address, addr);
  endtask

  task automatic drive(input logic en, input logic rd, input logic [31:0] tgt, input logic rdy);
    bus.enable   = en;
    bus.redirect = rd;
    bus.target   = tgt;
    bus.ready    = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    chk_all(tag, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, Base);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    //            en    rd    tgt           rdy   valid pc_o          instr  count  flt   faddr         addr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       32'd0,  32'd0, 1'b0, 32'h0,       32'h0040_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0040_0000, 32'd0, 32'd0, 1'b0, 32'h0,      32'h0040_0004};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0040_0004, 32'd1, 32'd1, 1'b0, 32'h0,      32'h0040_0008};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0040_0008, 32'd2, 32'd2, 1'b0, 32'h0,      32'h0040_000C};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0040_0008, 32'd2, 32'd2, 1'b0, 32'h0,      32'h0040_000C};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0040_0008, 32'd2, 32'd2, 1'b0, 32'h0,      32'h0040_000C};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0040_0008, 32'd2, 32'd2, 1'b0, 32'h0,      32'h0040_000C};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0040_000C, 32'd3, 32'd3, 1'b0, 32'h0,      32'h0040_0010};
    vecs[8]  = '{1'b1, 1'b1, 32'h0040_0020, 1'b1, 1'b0, 32'h0040_000C, 32'd3, 32'd4, 1'b0, 32'h0,    32'h0040_0020};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0040_0020, 32'd8, 32'd4, 1'b0, 32'h0,      32'h0040_0024};
    vecs[10] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0040_0024, 32'd9, 32'd5, 1'b0, 32'h0,      32'h0040_0028};
    vecs[11] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0040_0024, 32'd9, 32'd5, 1'b0, 32'h0,      32'h0040_0028};
    vecs[12] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0040_0024, 32'd9, 32'd6, 1'b0, 32'h0,      32'h0040_0028};
    vecs[13] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0040_0024, 32'd9, 32'd6, 1'b0, 32'h0,      32'h0040_0028};
    vecs[14] = '{1'b0, 1'b1, 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0024, 32'd9, 32'd6, 1'b0, 32'h0,    32'h0040_0030};
    vecs[15] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0040_0024, 32'd9, 32'd6, 1'b0, 32'h0,      32'h0040_0030};
    vecs[16] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0040_0030, 32'd12, 32'd6, 1'b0, 32'h0,     32'h0040_0034};
    vecs[17] = '{1'b1, 1'b1, 32'h0040_0022, 1'b1, 1'b0, 32'h0040_0030, 32'd12, 32'd7, 1'b1, 32'h0040_0022, 32'h0040_0034};
    vecs[18] = '{1'b1, 1'b1, 32'h0040_0040, 1'b1, 1'b0, 32'h0040_0030, 32'd12, 32'd7, 1'b1, 32'h0040_0022, 32'h0040_0034};
    vecs[19] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0040_0030, 32'd12, 32'd7, 1'b1, 32'h0040_0022, 32'h0040_0034};

    step();
    do_reset("reset0");

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].en, vecs[i].rd, vecs[i].tgt, vecs[i].rdy);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc_o, vecs[i].instr,
              vecs[i].count, vecs[i].fault, vecs[i].faddr, vecs[i].addr);
    end

    // Reset out of FAULT
    drive(1'b1, 1'b1, 32'h0040_0021, 1'b1);
    do_reset("reset_fault");

    // Stream through all 64 words, then the next load attempt faults at the limit.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    for (int k = 0; k < 64; k++) begin
      step();
      if (k == 0 || k == 31 || k == 63)
        chk_all($sformatf("stream%0d", k), 1'b1, Base + 32'(4 * k), 32'(k), 32'(k), 1'b0,
                32'h0, Base + 32'(4 * k + 4));
    end
    step();
    chk_all("end_fault", 1'b0, 32'h0040_00FC, 32'd63, 32'd64, 1'b1, 32'h0040_0100,
            32'h0040_0100);
    step();
    chk_all("end_frozen", 1'b0, 32'h0040_00FC, 32'd63, 32'd64, 1'b1, 32'h0040_0100,
            32'h0040_0100);

    // Aligned redirect below the base: accepted, then the load attempt faults.
    do_reset("reset_low");
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    drive(1'b1, 1'b1, 32'h003F_FFFC, 1'b1);
    step();
    chk_all("low_redirect", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h003F_FFFC);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    chk_all("low_fault", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h003F_FFFC, 32'h003F_FFFC);

    // Reset mid-stall, with redirect and enable asserted in the same cycle.
    do_reset("reset_pre_stall");
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    step();
    step();
    chk_all("stall", 1'b1, 32'h0040_0000, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0040_0004);
    drive(1'b1, 1'b1, 32'h0040_0080, 1'b0);
    do_reset("reset_stall");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
